// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: byte-level command engine sitting behind a UART.
// Decodes SYNC/'W'/addr/data and SYNC/'R'/addr frames from the receive
// strobe stream, drives a simple 8-bit register bus, and answers each
// frame with 'K', 'D'+data or 'E' through the transmit handshake.
module uart_reg_bridge #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd520000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_available,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       tx_enable,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_DATA  = 8'h44;  // 'D'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_REG_WR,
    S_REG_RD,
    S_RD_CAP,
    S_TX1,
    S_TX1_WAIT,
    S_TX2,
    S_TX2_WAIT
  } state_t;

  state_t      r_state;
  logic [19:0] r_cnt;         // idle clocks since the last byte of the frame
  logic        r_is_read;     // current frame is a read
  logic        r_guard;       // skip the cycle before the UART raises busy
  logic [7:0]  r_rdata_hold;  // read data waiting for the second reply byte

  logic        w_in_frame;
  logic        w_timeout;
  logic [19:0] w_cnt_next;

  // Only the byte-collecting states are subject to the inter-byte timeout.
  assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_timeout  = (r_cnt == (TIMEOUT_CYCLES - 20'd1));
  // Saturate instead of wrapping so a huge TIMEOUT_CYCLES never aliases.
  assign w_cnt_next = (r_cnt == 20'hFFFFF) ? r_cnt : (r_cnt + 20'd1);
  assign busy       = (r_state != S_IDLE);

  // Command FSM with registered bus, transmit and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 20'd0;
      r_is_read    <= 1'b0;
      r_guard      <= 1'b0;
      r_rdata_hold <= 8'h00;
      tx_byte      <= 8'h00;
      tx_enable    <= 1'b0;
      reg_addr     <= 8'h00;
      reg_wdata    <= 8'h00;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      tx_enable <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;

      if (w_in_frame && w_timeout) begin
        // Timeout beats a coinciding byte: abandon the frame silently.
        r_state   <= S_IDLE;
        r_cnt     <= 20'd0;
        frame_err <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= 20'd0;
            if (rx_available && (rx_byte == SYNC_BYTE)) begin
              r_state <= S_CMD;
            end
          end

          S_CMD: begin
            if (rx_available) begin
              r_cnt <= 20'd0;
              if (rx_byte == CMD_WRITE) begin
                r_is_read <= 1'b0;
                r_state   <= S_ADDR;
              end else if (rx_byte == CMD_READ) begin
                r_is_read <= 1'b1;
                r_state   <= S_ADDR;
              end else begin
                r_is_read <= 1'b0;
                tx_byte   <= RSP_ERR;
                frame_err <= 1'b1;
                r_state   <= S_TX1;
              end
            end else begin
              r_cnt <= w_cnt_next;
            end
          end

          S_ADDR: begin
            // A SYNC value here is just an address; no resync inside a frame.
            if (rx_available) begin
              r_cnt    <= 20'd0;
              reg_addr <= rx_byte;
              if (r_is_read) begin
                reg_re  <= 1'b1;
                r_state <= S_REG_RD;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_cnt <= w_cnt_next;
            end
          end

          S_DATA: begin
            if (rx_available) begin
              r_cnt     <= 20'd0;
              reg_wdata <= rx_byte;
              reg_we    <= 1'b1;
              r_state   <= S_REG_WR;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end

          S_REG_WR: begin
            r_cnt   <= 20'd0;
            tx_byte <= RSP_ACK;
            r_state <= S_TX1;
          end

          S_REG_RD: begin
            // reg_re is high during this cycle; data arrives next cycle.
            r_cnt   <= 20'd0;
            r_state <= S_RD_CAP;
          end

          S_RD_CAP: begin
            r_cnt        <= 20'd0;
            r_rdata_hold <= reg_rdata;
            tx_byte      <= RSP_DATA;
            r_state      <= S_TX1;
          end

          S_TX1: begin
            r_cnt <= 20'd0;
            if (!is_transmitting) begin
              tx_enable <= 1'b1;
              r_guard   <= 1'b1;
              r_state   <= S_TX1_WAIT;
            end
          end

          S_TX1_WAIT: begin
            r_cnt <= 20'd0;
            if (r_guard) begin
              r_guard <= 1'b0;
            end else if (!is_transmitting) begin
              if (r_is_read) begin
                tx_byte <= r_rdata_hold;
                r_state <= S_TX2;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end

          S_TX2: begin
            r_cnt <= 20'd0;
            if (!is_transmitting) begin
              tx_enable <= 1'b1;
              r_guard   <= 1'b1;
              r_state   <= S_TX2_WAIT;
            end
          end

          S_TX2_WAIT: begin
            r_cnt <= 20'd0;
            if (r_guard) begin
              r_guard <= 1'b0;
            end else if (!is_transmitting) begin
              r_state <= S_IDLE;
            end
          end

          default: begin
            r_cnt   <= 20'd0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: a UART stand-in, a register-file responder,
// a frame-level reference model feeding an expected-event queue, and a
// monitor that pops and compares every strobe the bridge produces.
module tb_uart_reg_bridge;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [19:0] TO   = 20'd100;

  localparam int K_WE  = 0;
  localparam int K_RE  = 1;
  localparam int K_TX  = 2;
  localparam int K_ERR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_available = 1'b0;
  logic       is_transmitting;
  logic [7:0] tx_byte;
  logic       tx_enable;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       frame_err;

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] b;
    longint     due;   // -1: timing not checked
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  longint     last_c = 0;
  logic [7:0] bus_mem[256];
  logic [7:0] ref_mem[256];
  bit         mem_loaded = 1'b0;
  int         ucnt = 0;
  logic       force_busy = 1'b0;
  logic       its_edge = 1'b0;
  logic [7:0] txb_edge = 8'h00;

  uart_reg_bridge #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_byte         (rx_byte),
    .rx_available    (rx_available),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .tx_enable       (tx_enable),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_we          (reg_we),
    .reg_re          (reg_re),
    .reg_rdata       (reg_rdata),
    .busy            (busy),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h22) return 8'h5A;
    return 8'(i * 7 + 3);
  endfunction

  // UART stand-in: busy from the cycle after tx_enable for a random length.
  assign is_transmitting = (ucnt != 0) || force_busy;
  always @(posedge clk) begin
    if (tx_enable) ucnt <= 4 + int'($urandom_range(0, 12));
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end

  // Values the bridge saw at the clock edge, for handshake checks.
  always @(posedge clk) begin
    its_edge <= is_transmitting;
    txb_edge <= tx_byte;
  end

  // Register file: read data valid only the cycle after reg_re.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) bus_mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else if (reg_we) begin
      bus_mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_re ? bus_mem[reg_addr] : 8'($urandom);
  end

  function automatic string kname(input int k);
    case (k)
      K_WE:    return "reg_we";
      K_RE:    return "reg_re";
      K_TX:    return "tx";
      default: return "frame_err";
    endcase
  endfunction

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] b, input longint due);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s got a=%02h b=%02h cyc=%0d required=no event", kname(kind), a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b || (e.due >= 0 && e.due != cyc)) begin
        failures++;
        $display("FAIL event got %s a=%02h b=%02h cyc=%0d required %s a=%02h b=%02h due=%0d",
                 kname(kind), a, b, cyc, kname(e.kind), e.a, e.b, e.due);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (frame_err) check_ev(K_ERR, 8'h00, 8'h00);
      if (reg_we)    check_ev(K_WE, reg_addr, reg_wdata);
      if (reg_re)    check_ev(K_RE, reg_addr, 8'h00);
      if (tx_enable) begin
        check_ev(K_TX, tx_byte, 8'h00);
        checks++;
        if (txb_edge !== tx_byte) begin
          failures++;
          $display("FAIL tx_stable got prev=%02h now=%02h required equal", txb_edge, tx_byte);
        end
        checks++;
        if (its_edge !== 1'b0) begin
          failures++;
          $display("FAIL tx_gate got is_transmitting=%b at request required 0", its_edge);
        end
      end
    end
  endtask

  function automatic int rg();
    return int'($urandom_range(0, 3));
  endfunction

  task automatic put_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_available = 1'b1;
    last_c = cyc;
  endtask

  task automatic release_byte();
    @(negedge clk);
    rx_available = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    put_byte(b);
    release_byte();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(SYNC, rg());
    send_byte(8'h57, rg());
    send_byte(a, rg());
    repeat (rg()) @(negedge clk);
    put_byte(d);
    push(K_WE, a, d, last_c + 1);
    push(K_TX, 8'h4B, 8'h00, last_c + 3);
    ref_mem[a] = d;
    release_byte();
  endtask

  task automatic do_read(input logic [7:0] a, input bit second);
    send_byte(SYNC, rg());
    send_byte(8'h52, rg());
    repeat (rg()) @(negedge clk);
    put_byte(a);
    push(K_RE, a, 8'h00, last_c + 1);
    push(K_TX, 8'h44, 8'h00, last_c + 4);
    if (second) push(K_TX, ref_mem[a], 8'h00, -1);
    release_byte();
  endtask

  task automatic do_bad(input logic [7:0] c);
    send_byte(SYNC, rg());
    repeat (rg()) @(negedge clk);
    put_byte(c);
    push(K_ERR, 8'h00, 8'h00, last_c + 1);
    push(K_TX, 8'h45, 8'h00, last_c + 2);
    release_byte();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && !is_transmitting) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_idle got pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({tx_enable, reg_we, reg_re, frame_err, busy, tx_byte, reg_addr, reg_wdata} !== 29'd0) begin
      failures++;
      $display("FAIL %s got tx_en=%b we=%b re=%b err=%b busy=%b tx=%02h addr=%02h wdata=%02h required all 0",
               name, tx_enable, reg_we, reg_re, frame_err, busy, tx_byte, reg_addr, reg_wdata);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset_state");

    // Write frame
    do_write(8'h10, 8'h3C);
    wait_idle("write");

    // Read frame: addr 22 holds 5A
    do_read(8'h22, 1'b1);
    wait_idle("read");

    // Bad command, then a normal write
    do_bad(8'h99);
    wait_idle("bad_cmd");
    do_write(8'h33, 8'hC3);
    wait_idle("after_bad");

    // Timeout after SYNC,'W'
    send_byte(SYNC, 0);
    put_byte(8'h57);
    push(K_ERR, 8'h00, 8'h00, last_c + longint'(TO) + 1);
    release_byte();
    repeat (int'(TO) + 5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy got %b required 0", busy);
    end
    wait_idle("timeout");
    do_read(8'h01, 1'b1);
    wait_idle("after_timeout");

    // Garbage, SYNC as address, UART held busy
    force_busy = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(SYNC, 0);
    send_byte(8'h52, 0);
    put_byte(SYNC);
    push(K_RE, SYNC, 8'h00, last_c + 1);
    push(K_TX, 8'h44, 8'h00, -1);
    push(K_TX, ref_mem[SYNC], 8'h00, -1);
    release_byte();
    repeat (50) @(negedge clk);
    force_busy = 1'b0;
    send_byte(8'h57, 0);
    send_byte(8'h10, 0);
    send_byte(8'h3C, 0);
    wait_idle("backpressure");

    // Reset during the first reply byte of a read
    send_byte(SYNC, 0);
    send_byte(8'h52, 0);
    put_byte(8'h44);
    push(K_RE, 8'h44, 8'h00, last_c + 1);
    push(K_TX, 8'h44, 8'h00, last_c + 4);
    release_byte();
    n = 0;
    while (!tx_enable && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL reset_tx1 got no tx_enable required tx_enable within 40 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reply_reset");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    wait_idle("after_reset");

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        send_byte(b, rg());
      end
      case ($urandom_range(0, 2))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), 1'b1);
        default: begin
          b = 8'($urandom);
          while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
          do_bad(b);
        end
      endcase
      wait_idle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Byte-level command engine on the host side of the UART byte interface.
- Consumes received bytes (rx_byte/rx_available), decodes register read/write frames and drives a simple 8-bit register bus.
- Returns acknowledge/data/error frames through the UART transmit handshake (tx_byte/tx_enable/is_transmitting).
- Lets a PC configure HDMI test-pattern registers over the serial link.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 20'd520000, maximum idle clocks between bytes inside a frame (about 10 byte times at 50 MHz / 9600 baud).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_byte  in  8  received byte from UART, valid while rx_available=1
- rx_available  in  1  one-cycle strobe: rx_byte holds a new byte
- is_transmitting  in  1  UART transmitter busy
- tx_byte  out  8  byte to transmit
- tx_enable  out  1  one-cycle transmit request
- reg_addr  out  8  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- busy  out  1  high in any state other than IDLE
- frame_err  out  1  one-cycle pulse on timeout or bad command

Behaviour:
- Reset (synchronous, active-high): state=IDLE; tx_enable, reg_we, reg_re, frame_err = 0; tx_byte, reg_addr, reg_wdata = 8'h00; timeout counter = 0. Reset mid-frame or mid-response aborts immediately; no tx_enable is issued after reset.
- Frame formats:
  - Write: SYNC, 8'h57 ('W'), addr, data. Reply: 8'h4B ('K').
  - Read: SYNC, 8'h52 ('R'), addr. Reply: 8'h44 ('D'), then data.
  - Any other command byte: reply 8'h45 ('E'), plus one frame_err pulse.
- States: IDLE, CMD, ADDR, DATA, REG_WR, REG_RD, RD_CAP, TX1, TX1_WAIT, TX2, TX2_WAIT.
- IDLE: on rx_available with rx_byte==SYNC_BYTE -> CMD. Other bytes are discarded silently.
- CMD: on a byte, latch the command.
  - 'W' or 'R' -> ADDR.
  - Else: set tx_byte='E', pulse frame_err -> TX1.
- ADDR: latch reg_addr.
  - Write -> DATA.
  - Read -> REG_RD.
- DATA: latch reg_wdata -> REG_WR.
- REG_WR: reg_we=1 for exactly one cycle; tx_byte='K' -> TX1.
- REG_RD: reg_re=1 for one cycle -> RD_CAP.
- RD_CAP: capture reg_rdata into an internal holding register; tx_byte='D' -> TX1.
- TX1: wait until is_transmitting==0, then pulse tx_enable for one cycle -> TX1_WAIT.
- TX1_WAIT:
  - Skip one guard cycle unconditionally; the UART raises is_transmitting the cycle after tx_enable.
  - Then wait for is_transmitting==0.
  - Read reply: tx_byte=held data -> TX2. Otherwise -> IDLE.
- TX2/TX2_WAIT: identical handshake -> IDLE.
- tx_byte is stable from one cycle before tx_enable until the next load.
- Timeout:
  - Counter clears on every rx_available and on entry to CMD; it increments each cycle in CMD/ADDR/DATA.
  - When it reaches TIMEOUT_CYCLES-1: -> IDLE, one frame_err pulse, no reply, no register access.
- Counter saturates and never wraps.
- No resync inside a frame: a SYNC value in ADDR/DATA is ordinary data.
- Bytes arriving in REG_*, RD_CAP and TX* states are dropped.
- rx_available coinciding with a timeout expiry: the timeout wins and the byte is dropped.
- Latency:
  - Last write byte strobe -> reg_we: 1 cycle.
  - reg_we -> tx_enable: 2 cycles if the UART is idle.
  - reg_re -> first tx_enable: 3 cycles if the UART is idle.

Test Plan:
- Write: bytes A5,57,10,3C -> one reg_we with reg_addr=10, reg_wdata=3C; then one tx_enable with tx_byte=4B; busy returns to 0; exactly one reg_we in the frame.
- Read: model returns 5A at addr 22; bytes A5,52,22 -> one reg_re, addr=22; tx_enable with 44, then after is_transmitting falls, tx_enable with 5A; two tx_enable pulses in total.
- Bad command: A5,99 -> frame_err pulse; tx 45; no reg_we/reg_re; next valid write frame is processed normally.
- Timeout (TIMEOUT_CYCLES=100): A5,57, then silence for 100 cycles -> frame_err pulse; state IDLE; no tx; a following A5,52,01 is read correctly.
- Garbage and back-pressure: 00,FF,A5,52,A5 with is_transmitting held high for 50 cycles -> addr=A5 is read; tx_enable is withheld until is_transmitting=0; extra bytes sent during the reply are ignored.
- Reset: assert rst during TX1_WAIT of a read -> all outputs zero next cycle; the second reply byte is never sent.
